// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS 5-stage pipeline front end.
//   - Opcode constants for the control-flow instructions resolved in ID.
//   - PC source select encodings consumed by the fetch stage.
//   - BTB command encodings (WriteEntry) consumed by the fetch stage.
//   - NOP instruction word used for pipeline bubbles.
package mips_pkg;

    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,   // sequential / BTB-predicted fetch
        PCSRC_BR  = 2'b01,   // branch target
        PCSRC_JMP = 2'b10    // jump address
    } pc_src_e;

    typedef enum logic [2:0] {
        WE_NONE      = 3'b000,  // no BTB action
        WE_ALLOC     = 3'b001,  // allocate entry for a taken branch
        WE_UPDATE    = 3'b010,  // hit predicted not-taken, actually taken
        WE_REDIR     = 3'b100,  // resume at pc_id+4 (alias hit)
        WE_REDIR_UPD = 3'b110   // resume at pc_id+4 and update entry
    } write_entry_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: combinational control-flow resolution for the ID stage.
// Ports:
//   opcode       in   instruction opcode field
//   rs_val       in   first register operand
//   rt_val       in   second register operand
//   find         in   instruction hit in the BTB at fetch
//   taken        in   BTB predicted taken at fetch
//   is_branch    out  beq or bne
//   is_jump      out  j or jal
//   actual_taken out  branch condition evaluated true
//   pc_src       out  fetch PC select
//   write_entry  out  BTB command
//   redirect     out  fetch went down the wrong path; flush IF/ID
module branch_resolve
    import mips_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [31:0]  rs_val,
    input  logic [31:0]  rt_val,
    input  logic         find,
    input  logic         taken,
    output logic         is_branch,
    output logic         is_jump,
    output logic         actual_taken,
    output pc_src_e      pc_src,
    output write_entry_e write_entry,
    output logic         redirect
);

    always_comb begin
        is_branch    = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump      = (opcode == OP_J) || (opcode == OP_JAL);
        actual_taken = ((opcode == OP_BEQ) && (rs_val == rt_val)) ||
                       ((opcode == OP_BNE) && (rs_val != rt_val));
        pc_src       = PCSRC_SEQ;
        write_entry  = WE_NONE;
        redirect     = 1'b0;

        if (is_branch) begin
            if (!find) begin
                if (actual_taken) begin
                    pc_src      = PCSRC_BR;
                    write_entry = WE_ALLOC;
                    redirect    = 1'b1;
                end
            end else if (taken) begin
                // Fetch already followed the BTB target; only a not-taken
                // outcome needs fetch to fall back to pc_id+4.
                if (!actual_taken) begin
                    write_entry = WE_REDIR_UPD;
                    redirect    = 1'b1;
                end
            end else if (actual_taken) begin
                pc_src      = PCSRC_BR;
                write_entry = WE_UPDATE;
                redirect    = 1'b1;
            end
        end else if (is_jump) begin
            // Jumps are resolved here every time and never enter the BTB.
            pc_src   = PCSRC_JMP;
            redirect = 1'b1;
        end else if (find && taken) begin
            // A non-branch aliased onto a taken BTB entry: undo the bogus
            // redirect by resuming at the sequential address.
            write_entry = WE_REDIR;
            redirect    = 1'b1;
        end
    end

endmodule

// File: rtl/if_id_branch_stage.sv
// if_id_branch_stage: IF/ID pipeline register with ID-stage branch
// resolution, fetch redirect control, wrong-path flush and statistics.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_in, pc_in,
//   pc_plus4_in           fetched instruction, its PC and PC+4
//   find_in_btb_in,
//   taken_in              BTB hit / prediction bits from fetch
//   stall                 hazard-unit hold of the IF/ID register
//   exc_flush             exception flush (overrides any redirect)
//   rs_val, rt_val        register operands for instr_id
//   instr_id, pc_id,
//   pc_plus4_id, valid_id registered ID-stage instruction state
//   pc_src, branch_target,
//   jmp_addr, write_entry fetch redirect controls
//   flush_if              redirect issued this cycle
//   branch_cnt,
//   mispred_cnt           saturating statistics counters
module if_id_branch_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      pc_plus4_in,
    input  logic             find_in_btb_in,
    input  logic             taken_in,
    input  logic             stall,
    input  logic             exc_flush,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic [31:0]      instr_id,
    output logic [31:0]      pc_id,
    output logic [31:0]      pc_plus4_id,
    output logic             valid_id,
    output logic [1:0]       pc_src,
    output logic [31:0]      branch_target,
    output logic [31:0]      jmp_addr,
    output logic [2:0]       write_entry,
    output logic             flush_if,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4_q, pc_plus4_d;
    logic             find_q, find_d;
    logic             taken_q, taken_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic         is_branch;
    logic         is_jump;
    logic         actual_taken;
    pc_src_e      res_pc_src;
    write_entry_e res_write_entry;
    logic         redirect;
    logic         act;
    logic         unused_actual_taken;

    branch_resolve u_resolve (
        .opcode       (instr_q[31:26]),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .find         (find_q),
        .taken        (taken_q),
        .is_branch    (is_branch),
        .is_jump      (is_jump),
        .actual_taken (actual_taken),
        .pc_src       (res_pc_src),
        .write_entry  (res_write_entry),
        .redirect     (redirect)
    );

    // The branch outcome is already folded into the resolver's commands.
    assign unused_actual_taken = actual_taken;

    // Bubbles, stalls and exceptions suppress every fetch-side side effect.
    assign act = valid_q & ~stall & ~exc_flush;

    always_comb begin
        pc_src        = act ? res_pc_src      : PCSRC_SEQ;
        write_entry   = act ? res_write_entry : WE_NONE;
        flush_if      = act & redirect;
        branch_target = pc_plus4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jmp_addr      = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    end

    always_comb begin
        instr_d    = instr_in;
        pc_d       = pc_in;
        pc_plus4_d = pc_plus4_in;
        find_d     = find_in_btb_in;
        taken_d    = taken_in;
        valid_d    = 1'b1;
        if (exc_flush || flush_if) begin
            instr_d    = NOP;
            pc_d       = '0;
            pc_plus4_d = '0;
            find_d     = 1'b0;
            taken_d    = 1'b0;
            valid_d    = 1'b0;
        end else if (stall) begin
            instr_d    = instr_q;
            pc_d       = pc_q;
            pc_plus4_d = pc_plus4_q;
            find_d     = find_q;
            taken_d    = taken_q;
            valid_d    = valid_q;
        end

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (act && is_branch) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
        end
        // Every branch or alias redirect is a fetch-path mistake; jumps
        // redirect by design and are not counted.
        if (flush_if && !is_jump) begin
            mispred_cnt_d = sat_inc(mispred_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q       <= NOP;
            pc_q          <= '0;
            pc_plus4_q    <= '0;
            find_q        <= 1'b0;
            taken_q       <= 1'b0;
            valid_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            find_q        <= find_d;
            taken_q       <= taken_d;
            valid_q       <= valid_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign instr_id    = instr_q;
    assign pc_id       = pc_q;
    assign pc_plus4_id = pc_plus4_q;
    assign valid_id    = valid_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_if_id_branch_stage.sv
// tb_if_id_branch_stage: directed-vector scoreboard bench for
// if_id_branch_stage (CNT_W = 4 so saturation is reachable quickly).
module tb_if_id_branch_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instr_in, pc_in, pc_plus4_in;
    logic             find_in_btb_in, taken_in, stall, exc_flush;
    logic [31:0]      rs_val, rt_val;
    logic [31:0]      instr_id, pc_id, pc_plus4_id;
    logic             valid_id;
    logic [1:0]       pc_src;
    logic [31:0]      branch_target, jmp_addr;
    logic [2:0]       write_entry;
    logic             flush_if;
    logic [CNT_W-1:0] branch_cnt, mispred_cnt;

    if_id_branch_stage #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_in       (instr_in),
        .pc_in          (pc_in),
        .pc_plus4_in    (pc_plus4_in),
        .find_in_btb_in (find_in_btb_in),
        .taken_in       (taken_in),
        .stall          (stall),
        .exc_flush      (exc_flush),
        .rs_val         (rs_val),
        .rt_val         (rt_val),
        .instr_id       (instr_id),
        .pc_id          (pc_id),
        .pc_plus4_id    (pc_plus4_id),
        .valid_id       (valid_id),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .jmp_addr       (jmp_addr),
        .write_entry    (write_entry),
        .flush_if       (flush_if),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Instruction words
    localparam logic [31:0] I_BEQ = 32'h1022_0004;  // beq $1,$2,+4
    localparam logic [31:0] I_BNE = 32'h1422_0008;  // bne $1,$2,+8
    localparam logic [31:0] I_J   = 32'h0800_0040;  // j 0x40
    localparam logic [31:0] I_ADD = 32'h0022_1820;  // add $3,$1,$2

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  src;
        logic [2:0]  we;
        logic        fl;
        logic        chk_tgt;
        logic [31:0] tgt;
        logic        chk_jmp;
        logic [31:0] jmp;
        logic [CNT_W-1:0] bcnt;
        logic [CNT_W-1:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic [CNT_W-1:0] eb = '0;
    logic [CNT_W-1:0] em = '0;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, ".valid_id"},    {31'b0, valid_id},  {31'b0, mon_e.valid});
            chk({mon_e.name, ".pc_id"},       pc_id,              mon_e.pc);
            chk({mon_e.name, ".pc_src"},      {30'b0, pc_src},    {30'b0, mon_e.src});
            chk({mon_e.name, ".write_entry"}, {29'b0, write_entry}, {29'b0, mon_e.we});
            chk({mon_e.name, ".flush_if"},    {31'b0, flush_if},  {31'b0, mon_e.fl});
            chk({mon_e.name, ".branch_cnt"},  {28'b0, branch_cnt}, {28'b0, mon_e.bcnt});
            chk({mon_e.name, ".mispred_cnt"}, {28'b0, mispred_cnt}, {28'b0, mon_e.mcnt});
            if (mon_e.chk_tgt) chk({mon_e.name, ".branch_target"}, branch_target, mon_e.tgt);
            if (mon_e.chk_jmp) chk({mon_e.name, ".jmp_addr"}, jmp_addr, mon_e.jmp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic f, input logic t);
        instr_in       = ins;
        pc_in          = pc;
        pc_plus4_in    = pc + 32'd4;
        find_in_btb_in = f;
        taken_in       = t;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [31:0] pc,
                              input logic [1:0] src, input logic [2:0] we, input logic fl,
                              input logic ct, input logic [31:0] tgt,
                              input logic cj, input logic [31:0] jmp);
        exp_t e;
        e.name = nm; e.valid = v; e.pc = pc; e.src = src; e.we = we; e.fl = fl;
        e.chk_tgt = ct; e.tgt = tgt; e.chk_jmp = cj; e.jmp = jmp;
        e.bcnt = eb; e.mcnt = em;
        exp_q.push_back(e);
    endtask

    task automatic expect_bubble(input string nm);
        expect_out(nm, 1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; exc_flush = 1'b0;
        rs_val = '0; rt_val = '0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        expect_bubble("reset");
        tick();
        reset = 1'b0;

        // Not-in-BTB taken beq: allocate + redirect, then a bubble.
        drive(I_BEQ, 32'h100, 1'b0, 1'b0);
        expect_bubble("idle0");
        tick();
        rs_val = 32'd5; rt_val = 32'd5;
        drive(I_ADD, 32'h104, 1'b0, 1'b0);
        expect_out("beq_alloc", 1'b1, 32'h100, 2'b01, 3'b001, 1'b1, 1'b1, 32'h114, 1'b0, 32'h0);
        tick();
        eb = sat(eb); em = sat(em);
        drive(I_BNE, 32'h200, 1'b1, 1'b1);
        expect_bubble("beq_bubble");
        tick();

        // bne hit, predicted taken, actually not taken.
        rs_val = 32'd7; rt_val = 32'd7;
        drive(I_ADD, 32'h224, 1'b0, 1'b0);
        expect_out("bne_redir_upd", 1'b1, 32'h200, 2'b00, 3'b110, 1'b1, 1'b1, 32'h224, 1'b0, 32'h0);
        tick();
        eb = sat(eb); em = sat(em);
        drive(I_BEQ, 32'h300, 1'b1, 1'b1);
        expect_bubble("bne_bubble");
        tick();

        // beq hit, predicted taken, actually taken: correct prediction.
        rs_val = 32'd3; rt_val = 32'd3;
        drive(I_ADD, 32'h310, 1'b0, 1'b0);
        expect_out("beq_correct", 1'b1, 32'h300, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        eb = sat(eb);
        rs_val = 32'd1; rt_val = 32'd2;
        drive(I_J, 32'h1000, 1'b0, 1'b0);
        expect_out("next_loads", 1'b1, 32'h310, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();

        // Jump: redirect, no BTB write, counters unchanged.
        drive(I_ADD, 32'h1004, 1'b0, 1'b0);
        expect_out("jump", 1'b1, 32'h1000, 2'b10, 3'b000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100);
        tick();
        drive(I_BEQ, 32'h400, 1'b0, 1'b0);
        expect_bubble("jump_bubble");
        tick();

        // Taken beq held for 3 stall cycles, then a single redirect.
        rs_val = 32'd9; rt_val = 32'd9;
        stall = 1'b1;
        drive(I_ADD, 32'h404, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("stall%0d", i), 1'b1, 32'h400, 2'b00, 3'b000, 1'b0,
                       1'b1, 32'h414, 1'b0, 32'h0);
            tick();
        end
        stall = 1'b0;
        expect_out("stall_release", 1'b1, 32'h400, 2'b01, 3'b001, 1'b1, 1'b1, 32'h414, 1'b0, 32'h0);
        tick();
        eb = sat(eb); em = sat(em);
        drive(I_ADD, 32'h500, 1'b1, 1'b1);
        expect_bubble("stall_bubble");
        tick();

        // Alias: non-branch hit with taken prediction.
        drive(I_ADD, 32'h504, 1'b0, 1'b0);
        expect_out("alias", 1'b1, 32'h500, 2'b00, 3'b100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        em = sat(em);
        drive(I_BEQ, 32'h600, 1'b0, 1'b0);
        expect_bubble("alias_bubble");
        tick();

        // exc_flush overrides a pending redirect: no write, no count.
        rs_val = 32'd4; rt_val = 32'd4;
        exc_flush = 1'b1;
        drive(I_ADD, 32'h604, 1'b0, 1'b0);
        expect_out("exc_flush", 1'b1, 32'h600, 2'b00, 3'b000, 1'b0, 1'b1, 32'h614, 1'b0, 32'h0);
        tick();
        exc_flush = 1'b0;
        drive(I_BEQ, 32'h800, 1'b0, 1'b0);
        expect_bubble("exc_bubble");
        tick();

        // Drive mispredicts until both counters saturate.
        rs_val = 32'd6; rt_val = 32'd6;
        for (int i = 0; i < 13; i++) begin
            drive(I_ADD, 32'h804, 1'b0, 1'b0);
            expect_out($sformatf("sat_br%0d", i), 1'b1, 32'h800, 2'b01, 3'b001, 1'b1,
                       1'b1, 32'h814, 1'b0, 32'h0);
            tick();
            eb = sat(eb); em = sat(em);
            drive(I_BEQ, 32'h800, 1'b0, 1'b0);
            expect_bubble($sformatf("sat_bub%0d", i));
            tick();
        end
        drive(I_ADD, 32'h700, 1'b0, 1'b0);
        expect_out("sat_final", 1'b1, 32'h800, 2'b01, 3'b001, 1'b1, 1'b1, 32'h814, 1'b0, 32'h0);
        tick();
        // counters already at all-ones stay there
        drive(I_ADD, 32'h700, 1'b0, 1'b0);
        expect_bubble("sat_hold");
        tick();

        // Reset asserted while stalled clears the register at the next edge.
        stall = 1'b1; reset = 1'b1;
        drive(I_ADD, 32'h704, 1'b0, 1'b0);
        expect_out("pre_reset", 1'b1, 32'h700, 2'b00, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        reset = 1'b0; stall = 1'b0;
        eb = '0; em = '0;
        expect_bubble("mid_stall_reset");
        tick();

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
